frame_level_ctrl: RTL
=====================

Name: frame_level_ctrl

Overview:
Frame-synchronous level scheduler that feeds the VU-meter VGA renderer's 8-bit data input. It accepts audio magnitude samples and tracks the per-frame maximum. The displayed level and peak-hold value change only once per frame, at the start of the vertical sync pulse, so the renderer never sees a value change mid-frame. The block sits between the audio front end and the VGA timing block, in the pixel_clock domain.

Parameters:
SAMPLE_W, 8, width of sample, level and peak (must equal the VGA data width)
DECAY_FRAMES, 4, frames between level decay steps (>=1)
DECAY_STEP, 2, amount subtracted from level per decay step
HOLD_FRAMES, 30, frames the peak is held before it starts to fall
V_POL, 0, active polarity of the v_sync input (0 = active low)

Ports:
pixel_clock  input  1  clock shared with the VGA timing block
reset_n  input  1  asynchronous, active-low reset
v_sync  input  1  registered vertical sync from the VGA block, synchronous to pixel_clock
sample_valid  input  1  sample present this cycle
sample  input  SAMPLE_W  unsigned sample magnitude
sample_ready  output  1  block accepts a sample this cycle
level  output  SAMPLE_W  displayed level, drives the VGA data input
peak  output  SAMPLE_W  peak-hold value
frame_tick  output  1  one-cycle pulse when level and peak update

Behaviour:
- Reset (asynchronous, reset_n=0): state=ACCUM; frame_max, cand, level and peak = 0; decay_cnt and hold_cnt = 0; frame_tick=0; v_sync_d = !V_POL. sample_ready=1 after reset is released.
- Edge detect: v_sync_d is v_sync delayed by one register. edge = (v_sync==V_POL) && (v_sync_d!=V_POL). The first frame after reset is therefore detected correctly.
- A sample is accepted when sample_valid && sample_ready. sample_ready=1 only in state ACCUM (combinational from the state).
- State ACCUM: on each accepted sample, frame_max <= max(frame_max, sample). On edge, go to LATCH. A sample accepted in the edge cycle counts toward the ending frame.
- State LATCH (1 cycle): cand <= frame_max; frame_max <= 0. Go to UPDATE.
- State UPDATE (1 cycle): frame_tick=1; registered outputs take their new values on the cycle that leaves UPDATE. Go to ACCUM.
  - Level rule:
    - If cand >= level: level <= cand; decay_cnt <= 0.
    - Else if decay_cnt == DECAY_FRAMES-1: level <= max(level-DECAY_STEP, cand), with the subtraction saturating at 0; decay_cnt <= 0.
    - Else: decay_cnt <= decay_cnt+1.
  - Peak rule:
    - If cand >= peak: peak <= cand; hold_cnt <= HOLD_FRAMES.
    - Else if hold_cnt != 0: hold_cnt <= hold_cnt-1.
    - Else: peak <= max(peak-1, new level).
- Edge to update latency: the edge is seen in cycle N, LATCH is N+1, UPDATE is N+2, and the new level/peak are visible at N+3.
- sample_ready=0 for exactly 2 cycles per frame (LATCH and UPDATE). Upstream must hold or drop samples during those cycles.
- An edge arriving in LATCH or UPDATE is ignored. It cannot occur with legal VGA timing.
- level and peak change only inside the sync pulse, never during the active video area.
- Invariant: peak >= level after every update.
- Counter widths: decay_cnt and hold_cnt use $clog2(DECAY_FRAMES+1) and $clog2(HOLD_FRAMES+1) bits respectively. No wrap is possible.
- Reset asserted mid-frame: all state clears at once and the partial frame_max is discarded.

Optional Feature:
FRAME_LEVEL_PEAK_HOLD_EN
- Defined: peak tracking and hold_cnt are implemented as described above.
- Undefined: the hold_cnt and peak registers are not built; peak is a continuous copy of level (equal to level in every cycle). All other behaviour is unchanged.

Test Plan:
- Reset release, no samples, 3 frames -> level=0, peak=0, one frame_tick per frame; sample_ready=0 only in the 2 cycles after each edge.
- Samples 10, 200, 50 within one frame -> 3 cycles after the next edge, level=200 and peak=200; level and peak are unchanged before that cycle.
- Level 200, then empty frames, DECAY_FRAMES=4, DECAY_STEP=2 -> level reads 198 after the 4th empty frame and 196 after the 8th.
- Peak 200, then frames with cand=0 -> peak holds 200 for 30 frames, then falls by 1 per frame and never goes below level.
- sample_valid held high across an edge with sample=255 in the edge cycle -> 255 counted in the old frame; the 2 following samples are not accepted (sample_ready=0).
- reset_n pulsed low mid-frame after a sample of 180 -> outputs are 0 immediately; the next frame update uses only samples received after reset.

Source files
------------

// File: rtl/frame_level_ctrl.sv
// Frame-synchronous level/peak scheduler for the VU-meter renderer (peak hold built with FRAME_LEVEL_PEAK_HOLD_EN).
// Latency: v_sync edge in cycle N -> LATCH N+1 -> UPDATE N+2 (frame_tick) -> new level/peak visible N+3.
// Backpressure: sample_ready drops for the LATCH and UPDATE cycles only; upstream holds or drops samples then.
module frame_level_ctrl #(
    parameter int SAMPLE_W     = 8,
    parameter int DECAY_FRAMES = 4,
    parameter int DECAY_STEP   = 2,
    parameter int HOLD_FRAMES  = 30,
    parameter bit V_POL        = 1'b0
) (
    input  logic                pixel_clock,
    input  logic                reset_n,
    input  logic                v_sync,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                sample_ready,
    output logic [SAMPLE_W-1:0] level,
    output logic [SAMPLE_W-1:0] peak,
    output logic                frame_tick
);

    localparam int DECAY_W = $clog2(DECAY_FRAMES + 1);
    localparam logic [DECAY_W-1:0]  DECAY_LAST = DECAY_W'(DECAY_FRAMES - 1);
    localparam logic [SAMPLE_W-1:0] STEP       = SAMPLE_W'(DECAY_STEP);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        LATCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  v_sync_q;
    logic [SAMPLE_W-1:0]   frame_max_q, frame_max_d;
    logic [SAMPLE_W-1:0]   cand_q, cand_d;
    logic [SAMPLE_W-1:0]   level_q, level_d;
    logic [DECAY_W-1:0]    decay_q, decay_d;
    logic [SAMPLE_W-1:0]   lvl_dec;
    logic                  sync_edge;
    logic                  accept;

`ifdef FRAME_LEVEL_PEAK_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [SAMPLE_W-1:0]   peak_q, peak_d;
    logic [SAMPLE_W-1:0]   peak_dec;

    assign peak_dec = peak_q - SAMPLE_W'(1);
`endif

    assign sync_edge    = (v_sync == V_POL) && (v_sync_q != V_POL);
    assign sample_ready = (state_q == ACCUM);
    assign accept       = sample_valid && sample_ready;
    assign frame_tick   = (state_q == UPDATE);
    assign lvl_dec      = (level_q >= STEP) ? (level_q - STEP) : '0;
    assign level        = level_q;

    always_comb begin
        state_d     = state_q;
        frame_max_d = frame_max_q;
        cand_d      = cand_q;
        level_d     = level_q;
        decay_d     = decay_q;
`ifdef FRAME_LEVEL_PEAK_HOLD_EN
        peak_d      = peak_q;
        hold_d      = hold_q;
`endif
        case (state_q)
            ACCUM: begin
                // A sample landing in the edge cycle still belongs to the ending frame.
                if (accept && (sample > frame_max_q)) begin
                    frame_max_d = sample;
                end
                if (sync_edge) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                cand_d      = frame_max_q;
                frame_max_d = '0;
                state_d     = UPDATE;
            end
            UPDATE: begin
                if (cand_q >= level_q) begin
                    level_d = cand_q;
                    decay_d = '0;
                end else if (decay_q == DECAY_LAST) begin
                    level_d = (lvl_dec > cand_q) ? lvl_dec : cand_q;
                    decay_d = '0;
                end else begin
                    decay_d = decay_q + DECAY_W'(1);
                end
`ifdef FRAME_LEVEL_PEAK_HOLD_EN
                // Falling peak is floored at the freshly computed level to keep peak >= level.
                if (cand_q >= peak_q) begin
                    peak_d = cand_q;
                    hold_d = HOLD_W'(HOLD_FRAMES);
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    peak_d = (peak_dec > level_d) ? peak_dec : level_d;
                end
`endif
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            v_sync_q    <= !V_POL;
            frame_max_q <= '0;
            cand_q      <= '0;
            level_q     <= '0;
            decay_q     <= '0;
        end else begin
            state_q     <= state_d;
            v_sync_q    <= v_sync;
            frame_max_q <= frame_max_d;
            cand_q      <= cand_d;
            level_q     <= level_d;
            decay_q     <= decay_d;
        end
    end

`ifdef FRAME_LEVEL_PEAK_HOLD_EN
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = level_q;
`endif

endmodule
